mblock_stage_ctrl: RTL and testbench

Per-instruction memory-stage sequencer that sits directly upstream of the memory-block address mux. It owns the program counter and walks each instruction through up to four memory stages: fetch, operand 1 read, operand 2 read and write-back. In each stage it presents that stage's address, write flag and source selector, and holds them until the memory block acknowledges. Stages the decoded instruction does not need are skipped.

---
 rtl/mblock_stage_ctrl_pkg.sv | 40 ++++
 rtl/mblock_pc_reg.sv | 23 ++
 rtl/mblock_stage_ctrl.sv | 128 ++++++++++++
 tb/tb_mblock_stage_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mblock_stage_ctrl_pkg.sv
// Shared constants for the memory-stage sequencer and the memory-block address mux.
// Holds the sequencer state encoding, the stage indices and the mblock source selector codes.
package mblock_stage_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_OP1,
        ST_OP2,
        ST_WB,
        ST_NEXT,
        ST_HALTED
    } state_t;

    localparam logic [1:0] STAGE_FETCH = 2'd0;
    localparam logic [1:0] STAGE_OP1   = 2'd1;
    localparam logic [1:0] STAGE_OP2   = 2'd2;
    localparam logic [1:0] STAGE_WB    = 2'd3;

    localparam logic [1:0] SEL_RAM   = 2'd0;
    localparam logic [1:0] SEL_BROM  = 2'd1;
    localparam logic [1:0] SEL_IO    = 2'd2;
    localparam logic [1:0] SEL_CONST = 2'd3;

    // Picks the first stage still needed; callers mask off stages already behind them.
    function automatic state_t next_needed(input logic need_op1,
                                           input logic need_op2,
                                           input logic need_wb);
        if (need_op1) begin
            return ST_OP1;
        end else if (need_op2) begin
            return ST_OP2;
        end else if (need_wb) begin
            return ST_WB;
        end else begin
            return ST_NEXT;
        end
    endfunction

endpackage

// File: rtl/mblock_pc_reg.sv
// Program counter register: steps by PC_STEP or loads the jump target when advanced.
// Arithmetic is 16-bit and wraps around.
module mblock_pc_reg #(
    parameter int          PC_STEP  = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    input  logic        is_jump,
    input  logic [15:0] jump_target,
    output logic [15:0] pc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (advance) begin
            pc <= is_jump ? jump_target : pc + 16'(PC_STEP);
        end
    end

endmodule

// File: rtl/mblock_stage_ctrl.sv
// Per-instruction memory-stage sequencer: walks fetch, operand reads and write-back,
// holding each stage's address and selector until the memory block acknowledges.
module mblock_stage_ctrl
    import mblock_stage_ctrl_pkg::*;
#(
    parameter int          PC_STEP  = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        execute_from_brom,
    input  logic        mblock_ready,
    input  logic        use_op1,
    input  logic        use_op2,
    input  logic        use_wb,
    input  logic [15:0] op1_addr,
    input  logic [15:0] op2_addr,
    input  logic [15:0] wb_addr,
    input  logic [1:0]  src_sel,
    input  logic        is_jump,
    input  logic [15:0] jump_target,
    input  logic        halt_req,
    output logic [15:0] address0,
    output logic [15:0] address1,
    output logic [15:0] address2,
    output logic [15:0] address3,
    output logic        is_write0,
    output logic        is_write1,
    output logic        is_write2,
    output logic        is_write3,
    output logic [1:0]  stage,
    output logic [1:0]  mblock_selector,
    output logic        mem_req,
    output logic        instr_valid,
    output logic [15:0] pc,
    output logic        halted
);

    state_t state;
    state_t state_nxt;
    logic   brom_mode;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            brom_mode   <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            instr_valid <= (state == ST_FETCH) && mblock_ready;
            if (state == ST_IDLE) begin
                brom_mode <= execute_from_brom;
            end
        end
    end

    // Stage-needed flags are read as each stage is left, so the decoder must hold them.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   state_nxt = ST_FETCH;
            ST_FETCH:  if (mblock_ready) state_nxt = next_needed(use_op1, use_op2, use_wb);
            ST_OP1:    if (mblock_ready) state_nxt = next_needed(1'b0, use_op2, use_wb);
            ST_OP2:    if (mblock_ready) state_nxt = next_needed(1'b0, 1'b0, use_wb);
            ST_WB:     if (mblock_ready) state_nxt = ST_NEXT;
            ST_NEXT:   state_nxt = halt_req ? ST_HALTED : ST_FETCH;
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        address0        = 16'h0000;
        address1        = 16'h0000;
        address2        = 16'h0000;
        address3        = 16'h0000;
        is_write0       = 1'b0;
        is_write1       = 1'b0;
        is_write2       = 1'b0;
        is_write3       = 1'b0;
        stage           = STAGE_FETCH;
        mblock_selector = SEL_RAM;
        mem_req         = 1'b0;
        halted          = 1'b0;
        case (state)
            ST_FETCH: begin
                address0        = pc;
                stage           = STAGE_FETCH;
                mblock_selector = brom_mode ? SEL_BROM : SEL_RAM;
                mem_req         = 1'b1;
            end
            ST_OP1: begin
                address1        = op1_addr;
                stage           = STAGE_OP1;
                mblock_selector = src_sel;
                mem_req         = 1'b1;
            end
            ST_OP2: begin
                address2        = op2_addr;
                stage           = STAGE_OP2;
                mblock_selector = src_sel;
                mem_req         = 1'b1;
            end
            ST_WB: begin
                address3        = wb_addr;
                is_write3       = 1'b1;
                stage           = STAGE_WB;
                mblock_selector = src_sel;
                mem_req         = 1'b1;
            end
            ST_HALTED: halted = 1'b1;
            default: ;
        endcase
    end

    mblock_pc_reg #(
        .PC_STEP  (PC_STEP),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .reset       (reset),
        .advance     (state == ST_NEXT),
        .is_jump     (is_jump),
        .jump_target (jump_target),
        .pc          (pc)
    );

endmodule

// File: tb/tb_mblock_stage_ctrl.sv
// Self-checking bench for mblock_stage_ctrl: each instruction is described as the list of
// accesses it must perform and the PC it must leave behind, then driven with random wait states.
module tb_mblock_stage_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        execute_from_brom = 1'b0;
    logic        mblock_ready = 1'b0;
    logic        use_op1 = 1'b0;
    logic        use_op2 = 1'b0;
    logic        use_wb = 1'b0;
    logic [15:0] op1_addr = 16'h0;
    logic [15:0] op2_addr = 16'h0;
    logic [15:0] wb_addr = 16'h0;
    logic [1:0]  src_sel = 2'd0;
    logic        is_jump = 1'b0;
    logic [15:0] jump_target = 16'h0;
    logic        halt_req = 1'b0;
    logic [15:0] address0, address1, address2, address3;
    logic        is_write0, is_write1, is_write2, is_write3;
    logic [1:0]  stage;
    logic [1:0]  mblock_selector;
    logic        mem_req;
    logic        instr_valid;
    logic [15:0] pc;
    logic        halted;

    logic [15:0] addr_v [4];
    assign addr_v[0] = address0;
    assign addr_v[1] = address1;
    assign addr_v[2] = address2;
    assign addr_v[3] = address3;

    typedef struct {
        logic [1:0]  stg;
        logic [15:0] adr;
        logic [1:0]  sel;
        logic        wr;
    } acc_t;

    int          total = 0;
    int          bad = 0;
    int          ninstr = 0;
    logic [15:0] exp_pc;
    logic        exp_brom;

    always #5 clk = ~clk;

    mblock_stage_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .execute_from_brom (execute_from_brom),
        .mblock_ready      (mblock_ready),
        .use_op1           (use_op1),
        .use_op2           (use_op2),
        .use_wb            (use_wb),
        .op1_addr          (op1_addr),
        .op2_addr          (op2_addr),
        .wb_addr           (wb_addr),
        .src_sel           (src_sel),
        .is_jump           (is_jump),
        .jump_target       (jump_target),
        .halt_req          (halt_req),
        .address0          (address0),
        .address1          (address1),
        .address2          (address2),
        .address3          (address3),
        .is_write0         (is_write0),
        .is_write1         (is_write1),
        .is_write2         (is_write2),
        .is_write3         (is_write3),
        .stage             (stage),
        .mblock_selector   (mblock_selector),
        .mem_req           (mem_req),
        .instr_valid       (instr_valid),
        .pc                (pc),
        .halted            (halted)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // No access in flight: every per-stage output at its idle value.
    task automatic checkQuiet(input string tag);
        checkOutput({tag, ".mem_req"}, 32'(mem_req), 32'd0);
        checkOutput({tag, ".stage"}, 32'(stage), 32'd0);
        checkOutput({tag, ".sel"}, 32'(mblock_selector), 32'd0);
        checkOutput({tag, ".wr"}, 32'({is_write0, is_write1, is_write2, is_write3}), 32'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("%s.addr%0d", tag, i), 32'(addr_v[i]), 32'd0);
        end
    endtask

    task automatic checkAccess(input string tag, input acc_t a);
        checkOutput({tag, ".mem_req"}, 32'(mem_req), 32'd1);
        checkOutput({tag, ".stage"}, 32'(stage), 32'(a.stg));
        checkOutput({tag, ".sel"}, 32'(mblock_selector), 32'(a.sel));
        checkOutput({tag, ".wr"}, 32'({is_write0, is_write1, is_write2, is_write3}), 32'(a.wr));
        checkOutput({tag, ".halted"}, 32'(halted), 32'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("%s.addr%0d", tag, i), 32'(addr_v[i]),
                        (i == int'(a.stg)) ? 32'(a.adr) : 32'd0);
        end
    endtask

    // Reset, check the IDLE cycle, and leave the bench one cycle into FETCH.
    task automatic doReset(input logic brom);
        reset = 1'b1;
        execute_from_brom = brom;
        mblock_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkQuiet("idle");
        checkOutput("idle.pc", 32'(pc), 32'h0000);
        checkOutput("idle.halted", 32'(halted), 32'd0);
        checkOutput("idle.instr_valid", 32'(instr_valid), 32'd0);
        @(posedge clk); #1;
        exp_pc = 16'h0000;
        exp_brom = brom;
        execute_from_brom = ~brom;
    endtask

    // Runs one instruction from its FETCH cycle through NEXT. waitc < 0 means random waits.
    task automatic applyStimulus(input logic u1, input logic u2, input logic u3,
                                 input logic [15:0] a1, input logic [15:0] a2,
                                 input logic [15:0] a3, input logic [1:0] src,
                                 input logic jmp, input logic [15:0] tgt,
                                 input logic hlt, input int waitc);
        acc_t accs[$];
        acc_t a;
        string tag;
        int w;
        use_op1 = u1; use_op2 = u2; use_wb = u3;
        op1_addr = a1; op2_addr = a2; wb_addr = a3;
        src_sel = src; is_jump = jmp; jump_target = tgt;
        halt_req = 1'b0;
        a.stg = 2'd0; a.adr = exp_pc; a.sel = {1'b0, exp_brom}; a.wr = 1'b0; accs.push_back(a);
        if (u1) begin a.stg = 2'd1; a.adr = a1; a.sel = src; a.wr = 1'b0; accs.push_back(a); end
        if (u2) begin a.stg = 2'd2; a.adr = a2; a.sel = src; a.wr = 1'b0; accs.push_back(a); end
        if (u3) begin a.stg = 2'd3; a.adr = a3; a.sel = src; a.wr = 1'b1; accs.push_back(a); end
        for (int idx = 0; idx < accs.size(); idx++) begin
            w = (waitc < 0) ? int'($urandom_range(0, 3)) : waitc;
            for (int c = 0; c <= w; c++) begin
                tag = $sformatf("i%0d.acc%0d.c%0d", ninstr, idx, c);
                checkAccess(tag, accs[idx]);
                checkOutput({tag, ".instr_valid"}, 32'(instr_valid), 32'(idx == 1 && c == 0));
                mblock_ready = (c == w);
                @(posedge clk); #1;
            end
            if (hlt) halt_req = 1'b1;
        end
        tag = $sformatf("i%0d.next", ninstr);
        checkQuiet(tag);
        checkOutput({tag, ".instr_valid"}, 32'(instr_valid), 32'(accs.size() == 1));
        checkOutput({tag, ".pc"}, 32'(pc), 32'(exp_pc));
        mblock_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        exp_pc = jmp ? tgt : exp_pc + 16'd4;
        checkOutput($sformatf("i%0d.pc", ninstr), 32'(pc), 32'(exp_pc));
        checkOutput($sformatf("i%0d.halted", ninstr), 32'(halted), 32'(hlt));
        if (hlt) checkQuiet($sformatf("i%0d.halt", ninstr));
        ninstr++;
    endtask

    initial begin
        acc_t a;
        doReset(1'b1);

        applyStimulus(1, 1, 1, 16'h0100, 16'h0104, 16'h0200, 2'd2, 0, 16'h0, 0, 0);
        applyStimulus(0, 0, 1, 16'h1111, 16'h2222, 16'h0300, 2'd0, 0, 16'h0, 0, 3);
        applyStimulus(0, 0, 0, 16'h0, 16'h0, 16'h0, 2'd1, 1, 16'h0040, 0, 0);
        applyStimulus(1, 0, 0, 16'h0050, 16'h0, 16'h0, 2'd3, 1, 16'hFFFC, 0, 1);
        applyStimulus(0, 1, 0, 16'h0, 16'h0060, 16'h0, 2'd0, 0, 16'h1234, 0, 0);
        checkOutput("wrap.pc", 32'(pc), 32'h0000);

        for (int k = 0; k < 40; k++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                          16'($urandom), 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) == 0), 16'($urandom), 0, -1);
        end

        applyStimulus(1, 0, 1, 16'h0700, 16'h0, 16'h0704, 2'd1, 0, 16'h0, 1, 1);
        for (int k = 0; k < 5; k++) begin
            mblock_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            checkQuiet($sformatf("stay%0d", k));
            checkOutput($sformatf("stay%0d.halted", k), 32'(halted), 32'd1);
        end

        doReset(1'b1);
        use_op1 = 0; use_op2 = 0; use_wb = 1; wb_addr = 16'h0ABC; src_sel = 2'd2;
        is_jump = 0; halt_req = 0; mblock_ready = 1;
        @(posedge clk); #1;
        mblock_ready = 0;
        a.stg = 2'd3; a.adr = 16'h0ABC; a.sel = 2'd2; a.wr = 1'b1;
        checkAccess("rwb0", a);
        @(posedge clk); #1;
        checkAccess("rwb1", a);
        #3 reset = 1'b1;
        #1;
        checkQuiet("async");
        checkOutput("async.pc", 32'(pc), 32'h0000);
        checkOutput("async.halted", 32'(halted), 32'd0);
        checkOutput("async.instr_valid", 32'(instr_valid), 32'd0);
        doReset(1'b0);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                          16'($urandom), 2'($urandom_range(0, 3)), 0, 16'h0, 0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
